// File: rtl/pll_reset_sequencer.sv
// PLL power-up sequencer: pulses the PLL reset, qualifies a debounced lock,
// then releases the downstream resets in a staggered order.
//
// state     | meaning
// RESET_PLL | pll_rst held high for the reset pulse
// WAIT_LOCK | waiting for synchronized lock, retry on timeout
// STABLE    | counting consecutive locked cycles
// RELEASE   | releasing rst_out bits in index order
// RUN       | all resets released, ready high
module pll_reset_sequencer #(
  parameter int NUM_RST          = 3,
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 1000000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int STAGGER_CYC      = 256
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               soft_reset,
  output logic               pll_rst,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic [7:0]         retry_cnt,
  output logic               lock_lost
);

  localparam int RELEASE_CYC = STAGGER_CYC * (NUM_RST - 1);
  localparam int MAX_A   = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_B   = (LOCK_STABLE_CYC > RELEASE_CYC) ? LOCK_STABLE_CYC : RELEASE_CYC;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYC);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sync1;
  logic          locked_s;
  logic          soft_hit;
  logic          drop_hit;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  assign soft_hit = soft_reset && (state != RESET_PLL);
  assign drop_hit = !locked_s && ((state == RELEASE) || (state == RUN));

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      rst_out   <= '1;
      ready     <= 1'b0;
      retry_cnt <= 8'd0;
      lock_lost <= 1'b0;
    end else if (soft_hit || drop_hit) begin
      // soft reset outranks lock loss, so only a genuine drop marks lock_lost
      state   <= RESET_PLL;
      cnt     <= '0;
      pll_rst <= 1'b1;
      rst_out <= '1;
      ready   <= 1'b0;
      if (!soft_hit) lock_lost <= 1'b1;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == PULSE_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state   <= RESET_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state      <= RELEASE;
            cnt        <= '0;
            rst_out[0] <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt == RELEASE_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            rst_out <= '0;
            ready   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
            for (int i = 1; i < NUM_RST; i++) begin
              if (cnt == CW'(STAGGER_CYC * i - 1)) rst_out[i] <= 1'b0;
            end
          end
        end
        RUN: begin
          rst_out <= '0;
          ready   <= 1'b1;
        end
        default: begin
          state   <= RESET_PLL;
          cnt     <= '0;
          pll_rst <= 1'b1;
          rst_out <= '1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expectations are queued with a due
// cycle when stimulus is applied and compared when that cycle is reached.
module tb_pll_reset_sequencer;

  localparam int NUM_RST          = 3;
  localparam int RST_PULSE_CYC    = 4;
  localparam int LOCK_TIMEOUT_CYC = 32;
  localparam int LOCK_STABLE_CYC  = 8;
  localparam int STAGGER_CYC      = 3;

  localparam int S_PLL = 0;
  localparam int S_RST = 1;
  localparam int S_RDY = 2;
  localparam int S_RTY = 3;
  localparam int S_LL  = 4;

  logic               refclk = 1'b0;
  logic               rst = 1'b1;
  logic               pll_locked = 1'b0;
  logic               soft_reset = 1'b0;
  logic               pll_rst;
  logic [NUM_RST-1:0] rst_out;
  logic               ready;
  logic [7:0]         retry_cnt;
  logic               lock_lost;

  pll_reset_sequencer #(
    .NUM_RST(NUM_RST),
    .RST_PULSE_CYC(RST_PULSE_CYC),
    .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
    .LOCK_STABLE_CYC(LOCK_STABLE_CYC),
    .STAGGER_CYC(STAGGER_CYC)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .soft_reset(soft_reset),
    .pll_rst(pll_rst),
    .rst_out(rst_out),
    .ready(ready),
    .retry_cnt(retry_cnt),
    .lock_lost(lock_lost)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    int          sig;
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] sig_val(input int sig);
    case (sig)
      S_PLL:   return {31'd0, pll_rst};
      S_RST:   return {29'd0, rst_out};
      S_RDY:   return {31'd0, ready};
      S_RTY:   return {24'd0, retry_cnt};
      default: return {31'd0, lock_lost};
    endcase
  endfunction

  task automatic sb_push(input string tag, input int sig, input int due, input logic [31:0] val);
    exp_t e;
    int   i;
    e.tag = tag;
    e.sig = sig;
    e.due = due;
    e.val = val;
    i = 0;
    while (i < sb_q.size() && sb_q[i].due <= due) i++;
    sb_q.insert(i, e);
  endtask

  task automatic sb_service();
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      chk(e.tag, sig_val(e.sig), e.val);
    end
  endtask

  always begin
    @(negedge refclk);
    #1;
    sb_service();
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge refclk);
  endtask

  task automatic drain();
    int lim;
    lim = 0;
    while (sb_q.size() > 0 && lim < 20000) begin
      @(negedge refclk);
      lim++;
    end
    @(negedge refclk);
    while (sb_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: never sampled, due cyc %0d", sb_q[0].tag, sb_q[0].due);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic do_reset(output int b);
    @(negedge refclk);
    rst = 1'b1;
    pll_locked = 1'b0;
    soft_reset = 1'b0;
    sb_push("rst_pll_rst", S_PLL, cyc + 1, 32'd1);
    sb_push("rst_rst_out", S_RST, cyc + 1, 32'd7);
    sb_push("rst_ready", S_RDY, cyc + 1, 32'd0);
    sb_push("rst_retry", S_RTY, cyc + 1, 32'd0);
    sb_push("rst_lock_lost", S_LL, cyc + 1, 32'd0);
    repeat (2) @(negedge refclk);
    rst = 1'b0;
    b = cyc;
  endtask

  task automatic pulse_soft();
    soft_reset = 1'b1;
    @(negedge refclk);
    soft_reset = 1'b0;
  endtask

  int b;
  int r;

  initial begin
    // nominal bring-up, then lock loss in RUN and re-sequence
    do_reset(b);
    for (int k = 0; k < 4; k++) sb_push("nom_pll_rst_hi", S_PLL, b + k, 32'd1);
    sb_push("nom_pll_rst_lo", S_PLL, b + 4, 32'd0);
    wait_cyc(b + 10);
    pll_locked = 1'b1;
    sb_push("nom_rst_out_held", S_RST, b + 20, 32'd7);
    sb_push("nom_rst0_rel", S_RST, b + 21, 32'd6);
    sb_push("nom_rst1_held", S_RST, b + 23, 32'd6);
    sb_push("nom_rst1_rel", S_RST, b + 24, 32'd4);
    sb_push("nom_rst2_held", S_RST, b + 26, 32'd4);
    sb_push("nom_rst2_rel", S_RST, b + 27, 32'd0);
    sb_push("nom_ready_lo", S_RDY, b + 27, 32'd0);
    sb_push("nom_ready_hi", S_RDY, b + 28, 32'd1);
    sb_push("nom_retry", S_RTY, b + 28, 32'd0);
    sb_push("nom_lock_lost", S_LL, b + 28, 32'd0);
    wait_cyc(b + 40);
    pll_locked = 1'b0;
    sb_push("loss_rst_out_2", S_RST, b + 42, 32'd0);
    sb_push("loss_ready_2", S_RDY, b + 42, 32'd1);
    sb_push("loss_rst_out_3", S_RST, b + 43, 32'd7);
    sb_push("loss_ready_3", S_RDY, b + 43, 32'd0);
    sb_push("loss_lock_lost", S_LL, b + 43, 32'd1);
    sb_push("loss_pll_rst_on", S_PLL, b + 43, 32'd1);
    sb_push("loss_pll_rst_end", S_PLL, b + 46, 32'd1);
    sb_push("loss_pll_rst_off", S_PLL, b + 47, 32'd0);
    sb_push("loss_retry", S_RTY, b + 47, 32'd0);
    wait_cyc(b + 50);
    pll_locked = 1'b1;
    sb_push("reseq_held", S_RST, b + 60, 32'd7);
    sb_push("reseq_rst0", S_RST, b + 61, 32'd6);
    sb_push("reseq_rst_all", S_RST, b + 67, 32'd0);
    sb_push("reseq_ready", S_RDY, b + 68, 32'd1);
    sb_push("reseq_lock_lost", S_LL, b + 68, 32'd1);
    drain();

    // unstable lock, then soft reset while rst_out = 110
    do_reset(b);
    wait_cyc(b + 6);
    pll_locked = 1'b1;
    sb_push("unst_no_early_rel", S_RST, b + 17, 32'd7);
    wait_cyc(b + 11);
    pll_locked = 1'b0;
    wait_cyc(b + 13);
    pll_locked = 1'b1;
    sb_push("unst_held", S_RST, b + 23, 32'd7);
    sb_push("unst_rel", S_RST, b + 24, 32'd6);
    sb_push("unst_retry", S_RTY, b + 24, 32'd0);
    wait_cyc(b + 25);
    sb_push("soft_pre", S_RST, b + 25, 32'd6);
    sb_push("soft_rst_out", S_RST, b + 26, 32'd7);
    sb_push("soft_lock_lost", S_LL, b + 26, 32'd0);
    sb_push("soft_ready", S_RDY, b + 26, 32'd0);
    sb_push("soft_pll_rst", S_PLL, b + 26, 32'd1);
    sb_push("soft_retry", S_RTY, b + 26, 32'd0);
    sb_push("soft_ign_pll_hi", S_PLL, b + 29, 32'd1);
    sb_push("soft_ign_pll_lo", S_PLL, b + 30, 32'd0);
    sb_push("soft_relock_held", S_RST, b + 38, 32'd7);
    sb_push("soft_relock_rel", S_RST, b + 39, 32'd6);
    pulse_soft();
    wait_cyc(b + 27);
    pulse_soft();
    drain();

    // soft reset coincident with a WAIT_LOCK timeout
    do_reset(b);
    sb_push("coinc_retry", S_RTY, b + 36, 32'd0);
    sb_push("coinc_pll_rst", S_PLL, b + 36, 32'd1);
    sb_push("coinc_lock_lost", S_LL, b + 36, 32'd0);
    sb_push("coinc_pulse_hi", S_PLL, b + 39, 32'd1);
    sb_push("coinc_pulse_lo", S_PLL, b + 40, 32'd0);
    sb_push("coinc_next_pre", S_RTY, b + 71, 32'd0);
    sb_push("coinc_next_to", S_RTY, b + 72, 32'd1);
    wait_cyc(b + 35);
    pulse_soft();
    drain();

    // async rst mid-STABLE
    do_reset(b);
    sb_push("async_retry_pre", S_RTY, b + 36, 32'd1);
    wait_cyc(b + 38);
    pll_locked = 1'b1;
    sb_push("async_pll_pre", S_PLL, b + 45, 32'd0);
    sb_push("async_retry_pre2", S_RTY, b + 45, 32'd1);
    sb_push("async_rst_out_pre", S_RST, b + 45, 32'd7);
    wait_cyc(b + 46);
    #3;
    rst = 1'b1;
    #1;
    sb_push("async_pll_rst", S_PLL, cyc, 32'd1);
    sb_push("async_retry", S_RTY, cyc, 32'd0);
    sb_push("async_rst_out", S_RST, cyc, 32'd7);
    sb_push("async_ready", S_RDY, cyc, 32'd0);
    sb_push("async_lock_lost", S_LL, cyc, 32'd0);
    sb_service();
    @(negedge refclk);
    rst = 1'b0;
    r = cyc;
    sb_push("async_restart_hi", S_PLL, r + 3, 32'd1);
    sb_push("async_restart_lo", S_PLL, r + 4, 32'd0);
    sb_push("async_relock_held", S_RST, r + 12, 32'd7);
    sb_push("async_relock_rel", S_RST, r + 13, 32'd6);
    drain();

    // repeated timeouts and retry saturation
    do_reset(b);
    sb_push("to_pll_lo", S_PLL, b + 35, 32'd0);
    sb_push("to_pll_hi", S_PLL, b + 36, 32'd1);
    sb_push("to_pll_hi_end", S_PLL, b + 39, 32'd1);
    sb_push("to_pll_lo2", S_PLL, b + 40, 32'd0);
    sb_push("to_retry0", S_RTY, b + 35, 32'd0);
    sb_push("to_retry1", S_RTY, b + 36, 32'd1);
    sb_push("to_retry1_hold", S_RTY, b + 71, 32'd1);
    sb_push("to_retry2", S_RTY, b + 72, 32'd2);
    sb_push("to_retry3", S_RTY, b + 108, 32'd3);
    sb_push("to_retry254", S_RTY, b + 36 * 255 - 1, 32'd254);
    sb_push("to_retry255", S_RTY, b + 36 * 255, 32'd255);
    sb_push("to_retry_sat", S_RTY, b + 36 * 256, 32'd255);
    sb_push("to_retry_sat300", S_RTY, b + 36 * 300 + 1, 32'd255);
    sb_push("to_rst_out", S_RST, b + 36 * 300 + 1, 32'd7);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
